// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with valid/ready flow control, flush-to-bubble,
// and an optional 2-entry skid buffer that keeps in_ready registered.
module pipe_stage_hs #(
  parameter int unsigned            WIDTH   = 32,
  parameter bit                     SKID_EN = 1'b1,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic [WIDTH-1:0] set_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_ready_q;
  logic             in_fire, out_fire;
  logic             load_main_in, load_main_skid, load_skid;

  // With the skid buffer, in_ready comes straight from a flop so no path exists from out_ready.
  assign in_ready = SKID_EN ? in_ready_q : (~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt    = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (in_fire && (out_fire || !SKID_EN)) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = SKID;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (out_fire) begin
          state_nxt      = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b1;
      main_q     <= RST_VAL;
      skid_q     <= RST_VAL;
    end else if (flush) begin
      // Skid contents are simply abandoned; the state no longer references them.
      state      <= EMPTY;
      out_valid  <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b1;
      main_q     <= set_data;
    end else begin
      state      <= state_nxt;
      out_valid  <= (state_nxt != EMPTY);
      count      <= 2'(state_nxt);
      in_ready_q <= (state_nxt != SKID);
      if (load_main_in)   main_q <= in_data;
      if (load_main_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: one instance with the skid buffer, one without.
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        rstn;
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_set_data, a_in_data, a_out_data;
  logic [1:0]  a_count;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_set_data, b_in_data, b_out_data;
  logic [1:0]  b_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.WIDTH(32), .SKID_EN(1'b1), .RST_VAL(32'h13)) dut_a (
    .clk(clk), .rstn(rstn), .flush(a_flush), .set_data(a_set_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count));

  pipe_stage_hs #(.WIDTH(32), .SKID_EN(1'b0), .RST_VAL(32'h13)) dut_b (
    .clk(clk), .rstn(rstn), .flush(b_flush), .set_data(b_set_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid got %0b want 0", a_out_valid); end
    n_cmp++; if (a_count !== 2'd0) begin n_bad++; $display("FAIL reset_a_count got %0d want 0", a_count); end
    n_cmp++; if (a_out_data !== 32'h13) begin n_bad++; $display("FAIL reset_a_data got %h want 13", a_out_data); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_ready got %0b want 1", a_in_ready); end
    n_cmp++; if (b_out_data !== 32'h13) begin n_bad++; $display("FAIL reset_b_data got %h want 13", b_out_data); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_ready got %0b want 1", b_in_ready); end
    rstn = 1'b1;
  endtask

  task automatic test_stream();
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_in_valid = 1'b1;  b_in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in_data = 32'(i); b_in_data = 32'(i + 16);
      step();
      n_cmp++; if (a_out_data !== 32'(i) || a_out_valid !== 1'b1 || a_count !== 2'd1)
        begin n_bad++; $display("FAIL stream_a[%0d] got d=%h v=%0b c=%0d want d=%h v=1 c=1", i, a_out_data, a_out_valid, a_count, i); end
      n_cmp++; if (b_out_data !== 32'(i + 16) || b_out_valid !== 1'b1)
        begin n_bad++; $display("FAIL stream_b[%0d] got d=%h v=%0b want d=%h v=1", i, b_out_data, b_out_valid, i + 16); end
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    step();
    n_cmp++; if (a_out_valid !== 1'b0 || a_count !== 2'd0 || a_out_data !== 32'd3)
      begin n_bad++; $display("FAIL stream_a_drain got v=%0b c=%0d d=%h want v=0 c=0 d=3", a_out_valid, a_count, a_out_data); end
    n_cmp++; if (b_out_valid !== 1'b0 || b_out_data !== 32'd19)
      begin n_bad++; $display("FAIL stream_b_drain got v=%0b d=%h want v=0 d=13h", b_out_valid, b_out_data); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
    step();
    n_cmp++; if (a_count !== 2'd1 || a_in_ready !== 1'b1 || a_out_data !== 32'hA)
      begin n_bad++; $display("FAIL bp_one got c=%0d r=%0b d=%h want c=1 r=1 d=a", a_count, a_in_ready, a_out_data); end
    a_in_data = 32'hB;
    step();
    n_cmp++; if (a_count !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 32'hA)
      begin n_bad++; $display("FAIL bp_two got c=%0d r=%0b d=%h want c=2 r=0 d=a", a_count, a_in_ready, a_out_data); end
    a_in_data = 32'hEE;
    step();
    n_cmp++; if (a_count !== 2'd2 || a_out_data !== 32'hA)
      begin n_bad++; $display("FAIL bp_hold got c=%0d d=%h want c=2 d=a", a_count, a_out_data); end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    step();
    n_cmp++; if (a_count !== 2'd1 || a_in_ready !== 1'b1 || a_out_data !== 32'hB)
      begin n_bad++; $display("FAIL bp_pop1 got c=%0d r=%0b d=%h want c=1 r=1 d=b", a_count, a_in_ready, a_out_data); end
    step();
    n_cmp++; if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== 32'hB)
      begin n_bad++; $display("FAIL bp_pop2 got c=%0d v=%0b d=%h want c=0 v=0 d=b", a_count, a_out_valid, a_out_data); end
  endtask

  task automatic test_flush_skid();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h5;
    step();
    a_in_data = 32'h6;
    step();
    n_cmp++; if (a_count !== 2'd2)
      begin n_bad++; $display("FAIL flush_fill got c=%0d want 2", a_count); end
    a_flush = 1'b1; a_set_data = 32'h13; a_in_data = 32'hC;
    step();
    n_cmp++; if (a_out_valid !== 1'b0 || a_count !== 2'd0 || a_out_data !== 32'h13 || a_in_ready !== 1'b1)
      begin n_bad++; $display("FAIL flush_skid got v=%0b c=%0d d=%h r=%0b want v=0 c=0 d=13 r=1", a_out_valid, a_count, a_out_data, a_in_ready); end
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h13)
        begin n_bad++; $display("FAIL flush_ghost[%0d] got v=%0b d=%h want v=0 d=13", i, a_out_valid, a_out_data); end
    end
  endtask

  task automatic test_noskid();
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h7;
    step();
    n_cmp++; if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 || b_count !== 2'd1)
      begin n_bad++; $display("FAIL noskid_stall got v=%0b r=%0b c=%0d want v=1 r=0 c=1", b_out_valid, b_in_ready, b_count); end
    b_in_data = 32'h8;
    step();
    n_cmp++; if (b_out_data !== 32'h7)
      begin n_bad++; $display("FAIL noskid_hold got d=%h want 7", b_out_data); end
    b_out_ready = 1'b1;
    #1;
    n_cmp++; if (b_in_ready !== 1'b1)
      begin n_bad++; $display("FAIL noskid_comb_ready got %0b want 1", b_in_ready); end
    step();
    n_cmp++; if (b_out_data !== 32'h8 || b_out_valid !== 1'b1 || b_count !== 2'd1)
      begin n_bad++; $display("FAIL noskid_replace got d=%h v=%0b c=%0d want d=8 v=1 c=1", b_out_data, b_out_valid, b_count); end
    b_in_valid = 1'b0;
    step();
    n_cmp++; if (b_out_valid !== 1'b0 || b_count !== 2'd0)
      begin n_bad++; $display("FAIL noskid_empty got v=%0b c=%0d want v=0 c=0", b_out_valid, b_count); end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h21;
    step();
    a_in_data = 32'h22;
    step();
    n_cmp++; if (a_count !== 2'd2)
      begin n_bad++; $display("FAIL rstmid_fill got c=%0d want 2", a_count); end
    rstn = 1'b0;
    step();
    n_cmp++; if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== 32'h13 || a_in_ready !== 1'b1)
      begin n_bad++; $display("FAIL rstmid got c=%0d v=%0b d=%h r=%0b want c=0 v=0 d=13 r=1", a_count, a_out_valid, a_out_data, a_in_ready); end
    rstn = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h13)
        begin n_bad++; $display("FAIL rstmid_ghost[%0d] got v=%0b d=%h want v=0 d=13", i, a_out_valid, a_out_data); end
    end
  endtask

  initial begin
    rstn = 1'b0;
    a_flush = 1'b0; a_set_data = '0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_set_data = '0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_skid();
    test_noskid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
